// File: rtl/pwm_multibridge.sv
// pwm_multibridge: center-aligned complementary PWM for CH half-bridge legs
// sharing one triangle carrier. Duties pass through shadow registers that are
// committed at the carrier valley. Each leg has its own dead-time counter,
// and a fault input forces every gate low.
// Build option: define PWM_MULTIBRIDGE_FAULT_LATCH_EN to make the fault sticky
// until fault_clr. Without it, the fault follows the registered protection input.
//
// Carrier direction FSM
//   state    | meaning
//   DIR_UP   | carrier counting 0 -> HALF_PERIOD-1 (top held one extra cycle)
//   DIR_DOWN | carrier counting HALF_PERIOD-1 -> 0 (valley held one extra cycle)
module pwm_multibridge #(
    parameter int CH          = 3,
    parameter int BW          = 16,
    parameter int HALF_PERIOD = 200,
    parameter int DEADTIME    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              protection,
    input  logic              fault_clr,
    input  logic              duty_load,
    input  logic [CH*BW-1:0]  duty,
    output logic [CH-1:0]     pwm_a,
    output logic [CH-1:0]     pwm_b,
    output logic [BW-1:0]     carrier,
    output logic              sync,
    output logic              fault_latched
);

    localparam logic [BW-1:0] HP_LIM  = BW'(HALF_PERIOD);
    localparam logic [BW-1:0] TOP     = BW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] DT      = BW'(DEADTIME);
    localparam logic [BW-1:0] ONE     = BW'(1);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    dir_e                   dir_q, dir_d;
    logic [BW-1:0]          carrier_q, carrier_d;
    logic [CH-1:0][BW-1:0]  shadow_q, shadow_d;
    logic [CH-1:0][BW-1:0]  act_q, act_d;
    logic [CH-1:0][BW-1:0]  dead_q, dead_d;
    logic [CH-1:0]          raw_q, raw_d;
    logic [CH-1:0]          a_q, a_d;
    logic [CH-1:0]          b_q, b_d;
    logic                   fault_q, fault_d;
    logic                   sync_w;

    // Valley cycle: last cycle of the period, where the shadow duty is committed.
    assign sync_w = (dir_q == DIR_DOWN) && (carrier_q == '0);

    // Carrier next state: endpoints flip direction without moving the count.
    always_comb begin
        dir_d     = dir_q;
        carrier_d = carrier_q;
        if (!en) begin
            dir_d     = DIR_UP;
            carrier_d = '0;
        end else begin
            case (dir_q)
                DIR_UP: begin
                    if (carrier_q >= TOP) dir_d = DIR_DOWN;
                    else                  carrier_d = carrier_q + ONE;
                end
                DIR_DOWN: begin
                    if (carrier_q == '0) dir_d = DIR_UP;
                    else                 carrier_d = carrier_q - ONE;
                end
                default: begin
                    dir_d     = DIR_UP;
                    carrier_d = '0;
                end
            endcase
        end
    end

    // Fault status: sticky until cleared, or a plain registered copy of protection.
    always_comb begin
`ifdef PWM_MULTIBRIDGE_FAULT_LATCH_EN
        fault_d = protection | (fault_q & ~fault_clr);
`else
        fault_d = protection;
`endif
    end

    // Per-leg shadow/active duty, compare, dead-time counter and gate decode.
    always_comb begin
        shadow_d = shadow_q;
        act_d    = act_q;
        raw_d    = raw_q;
        dead_d   = dead_q;
        a_d      = '0;
        b_d      = '0;
        for (int i = 0; i < CH; i++) begin
            if (duty_load) shadow_d[i] = duty[i*BW +: BW];
            // Active duty takes the pre-edge shadow, so a load in the sync cycle waits a period.
            if (sync_w) act_d[i] = (shadow_q[i] > HP_LIM) ? HP_LIM : shadow_q[i];
            raw_d[i] = en && (carrier_q < act_q[i]);
            // Reload whenever the target flips, the leg is disabled, or a fault holds the gates off;
            // the counter then reaches 0 exactly DEADTIME edges after the gates went low.
            if (!en || fault_d || (raw_d[i] != raw_q[i])) dead_d[i] = DT;
            else if (dead_q[i] != '0)                     dead_d[i] = dead_q[i] - ONE;
            if (en && !fault_d && (dead_q[i] == '0)) begin
                a_d[i] = raw_q[i];
                b_d[i] = ~raw_q[i];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= DIR_UP;
            carrier_q <= '0;
            shadow_q  <= '0;
            act_q     <= '0;
            raw_q     <= '0;
            dead_q    <= {CH{DT}};
            a_q       <= '0;
            b_q       <= '0;
            fault_q   <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            carrier_q <= carrier_d;
            shadow_q  <= shadow_d;
            act_q     <= act_d;
            raw_q     <= raw_d;
            dead_q    <= dead_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fault_q   <= fault_d;
        end
    end

    assign pwm_a         = a_q;
    assign pwm_b         = b_q;
    assign carrier       = carrier_q;
    assign sync          = sync_w;
    assign fault_latched = fault_q;

endmodule

// File: tb/tb_pwm_multibridge.sv
// Directed bench for pwm_multibridge with CH=3, BW=16, HALF_PERIOD=200, DEADTIME=10.
module tb_pwm_multibridge;
    localparam int CH = 3;
    localparam int BW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              protection = 1'b0;
    logic              fault_clr = 1'b0;
    logic              duty_load = 1'b0;
    logic [CH*BW-1:0]  duty = '0;
    logic [CH-1:0]     pwm_a;
    logic [CH-1:0]     pwm_b;
    logic [BW-1:0]     carrier;
    logic              sync;
    logic              fault_latched;

    int pass_cnt = 0;
    int total_cnt = 0;
    int a_cnt[CH];
    int b_cnt[CH];
    int both_cnt;
    int sync_cnt;
    int cmax;

    pwm_multibridge #(.CH(3), .BW(16), .HALF_PERIOD(200), .DEADTIME(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .protection(protection),
        .fault_clr(fault_clr), .duty_load(duty_load), .duty(duty),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .carrier(carrier), .sync(sync),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    task automatic load_duty(input logic [CH*BW-1:0] val);
        duty = val;
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
    endtask

    task automatic wait_sync();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sync !== 1'b1 && n < 1000);
        if (sync !== 1'b1) begin
            total_cnt++;
            $display("FAIL wait_sync timeout got sync=%b want 1 within 1000 cycles", sync);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            a_cnt[c] = 0;
            b_cnt[c] = 0;
        end
        both_cnt = 0;
        sync_cnt = 0;
        cmax = 0;
    endtask

    task automatic measure(input int ncyc, input int load_at, input logic [CH*BW-1:0] load_val);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                a_cnt[c] += int'(pwm_a[c]);
                b_cnt[c] += int'(pwm_b[c]);
            end
            if ((pwm_a & pwm_b) != '0) both_cnt++;
            if (sync) sync_cnt++;
            if (int'(carrier) > cmax) cmax = int'(carrier);
            duty_load = (i == load_at);
            if (i == load_at) duty = load_val;
        end
        duty_load = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (pwm_a !== 3'b000) $display("FAIL reset_pwm_a got %b want 000", pwm_a); else pass_cnt++;
        total_cnt++; if (pwm_b !== 3'b000) $display("FAIL reset_pwm_b got %b want 000", pwm_b); else pass_cnt++;
        total_cnt++; if (carrier !== 16'd0) $display("FAIL reset_carrier got %0d want 0", carrier); else pass_cnt++;
        total_cnt++; if (sync !== 1'b0) $display("FAIL reset_sync got %b want 0", sync); else pass_cnt++;
        total_cnt++; if (fault_latched !== 1'b0) $display("FAIL reset_fault got %b want 0", fault_latched); else pass_cnt++;
        rst_n = 1'b1;
        en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pwm_b[0] !== 1'b1 && n < 50);
        total_cnt++; if (n !== 11) $display("FAIL reset_pwm_b_rise got %0d clocks want 11", n); else pass_cnt++;
        total_cnt++; if (pwm_b !== 3'b111) $display("FAIL reset_pwm_b_all got %b want 111", pwm_b); else pass_cnt++;
        total_cnt++; if (pwm_a !== 3'b000) $display("FAIL reset_pwm_a_idle got %b want 000", pwm_a); else pass_cnt++;
        total_cnt++; if (carrier !== 16'd11) $display("FAIL reset_carrier_count got %0d want 11", carrier); else pass_cnt++;
    endtask

    task automatic test_basic_pwm();
        int ea[CH] = '{190, 90, 290};
        int eb[CH] = '{190, 290, 90};
        load_duty({16'd150, 16'd50, 16'd100});
        wait_sync();
        wait_sync();
        clear_counts();
        measure(400, -1, '0);
        for (int c = 0; c < CH; c++) begin
            total_cnt++; if (a_cnt[c] !== ea[c]) $display("FAIL basic_a_high ch%0d got %0d want %0d", c, a_cnt[c], ea[c]); else pass_cnt++;
            total_cnt++; if (b_cnt[c] !== eb[c]) $display("FAIL basic_b_high ch%0d got %0d want %0d", c, b_cnt[c], eb[c]); else pass_cnt++;
        end
        total_cnt++; if (both_cnt !== 0) $display("FAIL basic_overlap got %0d cycles want 0", both_cnt); else pass_cnt++;
        total_cnt++; if (sync_cnt !== 1) $display("FAIL basic_sync_per_period got %0d want 1", sync_cnt); else pass_cnt++;
    endtask

    task automatic test_shadow();
        wait_sync();
        clear_counts();
        measure(400, 100, {16'd150, 16'd50, 16'd40});
        total_cnt++; if (a_cnt[0] !== 190) $display("FAIL shadow_current_period got %0d want 190", a_cnt[0]); else pass_cnt++;
        clear_counts();
        measure(400, -1, '0);
        total_cnt++; if (a_cnt[0] !== 70) $display("FAIL shadow_next_period got %0d want 70", a_cnt[0]); else pass_cnt++;
        total_cnt++; if (sync !== 1'b1) $display("FAIL shadow_sync_align got %b want 1", sync); else pass_cnt++;
        duty = {16'd150, 16'd50, 16'd80};
        duty_load = 1'b1;
        clear_counts();
        measure(400, -1, '0);
        total_cnt++; if (a_cnt[0] !== 70) $display("FAIL shadow_sync_load_k1 got %0d want 70", a_cnt[0]); else pass_cnt++;
        clear_counts();
        measure(400, -1, '0);
        total_cnt++; if (a_cnt[0] !== 150) $display("FAIL shadow_sync_load_k2 got %0d want 150", a_cnt[0]); else pass_cnt++;
    endtask

    task automatic test_narrow();
        load_duty({16'd150, 16'd50, 16'd3});
        wait_sync();
        wait_sync();
        clear_counts();
        measure(400, -1, '0);
        total_cnt++; if (a_cnt[0] !== 0) $display("FAIL narrow_a_high got %0d want 0", a_cnt[0]); else pass_cnt++;
        total_cnt++; if (b_cnt[0] !== 384) $display("FAIL narrow_b_high got %0d want 384", b_cnt[0]); else pass_cnt++;
        total_cnt++; if (both_cnt !== 0) $display("FAIL narrow_overlap got %0d want 0", both_cnt); else pass_cnt++;
    endtask

    task automatic test_extremes();
        int ea[CH] = '{400, 0, 400};
        int eb[CH] = '{0, 400, 0};
        load_duty({16'd250, 16'd0, 16'd200});
        wait_sync();
        wait_sync();
        clear_counts();
        measure(400, -1, '0);
        for (int c = 0; c < CH; c++) begin
            total_cnt++; if (a_cnt[c] !== ea[c]) $display("FAIL extreme_a_high ch%0d got %0d want %0d", c, a_cnt[c], ea[c]); else pass_cnt++;
            total_cnt++; if (b_cnt[c] !== eb[c]) $display("FAIL extreme_b_high ch%0d got %0d want %0d", c, b_cnt[c], eb[c]); else pass_cnt++;
        end
        total_cnt++; if (cmax !== 199) $display("FAIL extreme_carrier_max got %0d want 199", cmax); else pass_cnt++;
    endtask

    task automatic test_fault();
        int n;
        load_duty({16'd150, 16'd50, 16'd100});
        wait_sync();
        wait_sync();
        repeat (5) @(negedge clk);
        total_cnt++; if (pwm_a[0] !== 1'b1) $display("FAIL fault_pre_high got %b want 1", pwm_a[0]); else pass_cnt++;
        protection = 1'b1;
        @(negedge clk);
        total_cnt++; if (pwm_a !== 3'b000) $display("FAIL fault_pwm_a got %b want 000", pwm_a); else pass_cnt++;
        total_cnt++; if (pwm_b !== 3'b000) $display("FAIL fault_pwm_b got %b want 000", pwm_b); else pass_cnt++;
        total_cnt++; if (fault_latched !== 1'b1) $display("FAIL fault_set got %b want 1", fault_latched); else pass_cnt++;
        fault_clr = 1'b1;
        @(negedge clk);
        total_cnt++; if (fault_latched !== 1'b1) $display("FAIL fault_clr_blocked got %b want 1", fault_latched); else pass_cnt++;
`ifdef PWM_MULTIBRIDGE_FAULT_LATCH_EN
        protection = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (fault_latched !== 1'b1) $display("FAIL fault_held got %b want 1", fault_latched); else pass_cnt++;
        total_cnt++; if ((pwm_a | pwm_b) !== 3'b000) $display("FAIL fault_held_gates got %b want 000", pwm_a | pwm_b); else pass_cnt++;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
`else
        protection = 1'b0;
        @(negedge clk);
        fault_clr = 1'b0;
`endif
        total_cnt++; if (fault_latched !== 1'b0) $display("FAIL fault_cleared got %b want 0", fault_latched); else pass_cnt++;
        n = 0;
        while ((pwm_a[0] | pwm_b[0]) == 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total_cnt++; if (n !== 10) $display("FAIL fault_recover_low got %0d clocks want 10", n); else pass_cnt++;
        total_cnt++; if (pwm_a[0] !== 1'b1) $display("FAIL fault_recover_side got %b want 1", pwm_a[0]); else pass_cnt++;
    endtask

    task automatic test_reset_enable();
        int n;
        logic [BW-1:0] c1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (pwm_a !== 3'b000) $display("FAIL async_rst_pwm_a got %b want 000", pwm_a); else pass_cnt++;
        total_cnt++; if (pwm_b !== 3'b000) $display("FAIL async_rst_pwm_b got %b want 000", pwm_b); else pass_cnt++;
        total_cnt++; if (carrier !== 16'd0) $display("FAIL async_rst_carrier got %0d want 0", carrier); else pass_cnt++;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (carrier !== 16'd0) $display("FAIL en_low_carrier got %0d want 0", carrier); else pass_cnt++;
        total_cnt++; if ((pwm_a | pwm_b) !== 3'b000) $display("FAIL en_low_gates got %b want 000", pwm_a | pwm_b); else pass_cnt++;
        en = 1'b1;
        n = 0;
        c1 = '0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) c1 = carrier;
        end while (pwm_b[0] !== 1'b1 && n < 50);
        total_cnt++; if (c1 !== 16'd1) $display("FAIL en_carrier_up got %0d want 1", c1); else pass_cnt++;
        total_cnt++; if (n !== 11) $display("FAIL en_pwm_b_rise got %0d clocks want 11", n); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_pwm();
        test_shadow();
        test_narrow();
        test_extremes();
        test_fault();
        test_reset_enable();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_multibridge.md
# pwm_multibridge

Multi-channel, center-aligned complementary PWM generator for N half-bridge legs sharing one triangle carrier. Per-channel duty goes through a shadow register and is applied only at the carrier valley. Dead time is enforced by a per-channel counter rather than by shifted compare thresholds. Adds a latched, clearable fault shutdown. It replaces single-leg bridge generators in multi-phase inverter designs.

## Interface
- `CH`, 3: number of half-bridge legs.
- `BW`, 16: carrier and duty width.
- `HALF_PERIOD`, 200: carrier half period in clocks. Range 2..2^BW-1. PWM period is 2*HALF_PERIOD.
- `DEADTIME`, 10: dead time in clocks. Range 1..2^BW-1.

Ports (clock and reset first):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable.
- `protection` in 1: fault request, active high.
- `fault_clr` in 1: clears the latched fault.
- `duty_load` in 1: strobe that captures `duty` into the shadow registers.
- `duty` in CH*BW: packed duties; channel i is at [i*BW +: BW].
- `pwm_a` out CH: high-side gate per channel.
- `pwm_b` out CH: low-side gate per channel.
- `carrier` out BW: current carrier count.
- `sync` out 1: one-cycle pulse in the last cycle of each period.
- `fault_latched` out 1: fault status.

## Operation
**Reset values.** Carrier 0, direction up. Active and shadow duties 0. `raw` 0. Dead counters = DEADTIME. `pwm_a`, `pwm_b`, `sync` and `fault_latched` all 0.

**Carrier.**
- Up phase counts 0..HALF_PERIOD-1; down phase counts HALF_PERIOD-1..0. Each endpoint is held for two cycles.
- Direction flips at an endpoint without changing the count.
- `en`=0: carrier returns to 0/up, `raw` is cleared, dead counters are reloaded, and all gates are low.

**Duty shadow.**
- `duty_load`=1 writes all CH values into the shadow registers.
- `sync`=1 when carrier==0 and direction is down. At the end of that cycle, active duty takes the shadow value.
- A `duty_load` in the same cycle as `sync` updates the shadow register only. It is applied at the next valley.
- Active duty saturates to HALF_PERIOD.

**Compare.**
- `raw[i]` is registered each cycle as (carrier < duty_act[i]).
- High time is exactly 2*duty per period. Duty 0 means never high; duty HALF_PERIOD means always high.

**Dead time (per channel).**
- When `raw[i]` changes, both gates go low and the dead counter reloads with DEADTIME.
- The counter decrements while nonzero. When it reaches 0, `pwm_a` = `raw` and `pwm_b` = !`raw`.
- If `raw` toggles again while counting, the counter restarts. Pulses of DEADTIME cycles or less therefore never reach the gates.
- Both gates are never high together.

**Fault.**
- `protection`=1 sets `fault_latched`.
- While latched, all gates are low; the carrier and duty logic keep running.
- `fault_clr`=1 with `protection`=0 clears the latch. If `protection` and `fault_clr` are both high, the fault remains set.
- On clear, dead counters reload, so gates resume only after DEADTIME low cycles.

## Timing
- Gates lag `raw` by one clock. The off-going gate falls one clock after `raw` changes.
- The on-coming gate rises exactly DEADTIME clocks after the off-going gate falls.
- `protection` forces gates low on the next rising edge. The same edge sets `fault_latched`.
- A duty loaded in period k affects gates starting in period k+1. If it is loaded during a `sync` cycle, it affects gates starting in period k+2.
- After reset with `en`=1 and duty 0: `pwm_b` rises after DEADTIME+1 clocks.
- Reset asserted mid-period: all outputs drop immediately (asynchronously).

## Configuration
- `PWM_MULTIBRIDGE_FAULT_LATCH_EN` defined: fault latching and `fault_clr` behave as described.
- Not defined: fault is non-latching.
  - Gates are low only while `protection`=1.
  - `fault_latched` mirrors the registered `protection`.
  - `fault_clr` is ignored.
  - Dead counters still reload when `protection` falls.

## Test plan
All scenarios use CH=3, BW=16, HALF_PERIOD=200, DEADTIME=10.
1. **Basic PWM:** load duties 100/50/150, en=1, wait one valley.
   - Ch0: `pwm_a` high 190 and `pwm_b` high 190 per 400-clock period, with two 10-cycle gaps.
   - Ch2: `pwm_a` 290, `pwm_b` 90.
2. **Shadow timing:** change ch0 duty to 40 mid-period.
   - Current period is unchanged.
   - The next period starts with `pwm_a` high 70.
   - Load during the `sync` cycle: applied one period later.
3. **Narrow pulse:** duty 3.
   - `pwm_a` never rises.
   - `pwm_b` goes low for 16 clocks per period.
   - No cycle has `pwm_a` & `pwm_b` both high.
4. **Extremes:** duty 0 gives `pwm_b` constantly high. Duty 250 saturates to 200 and gives `pwm_a` constantly high. Neither case produces dead gaps.
5. **Fault:** pulse `protection` mid-high-side.
   - All gates are low on the next edge and `fault_latched`=1.
   - `fault_clr` while `protection`=1 has no effect.
   - After clear, gates resume after 10 low clocks.
   - Without the macro, gates recover when `protection` drops.
6. **Reset/enable:** assert `rst_n`=0 mid-period, then drop `en`.
   - All outputs are 0 immediately after reset.
   - Carrier restarts at 0/up.
   - `pwm_b` rises 11 clocks after `en` returns.
